entry_controller: RTL and testbench

Keypad entry sequencer for the calculator input unit. It takes the raw key-press strobe and the 4-bit key code. It assembles two BCD operands digit by digit under a movable cursor, latches the operator, and launches the ALU with a start/done handshake. It then holds the result for display or chaining. It sits between the keypad encoder and the ALU, and drives the display digit bus and the cursor position.

---
 rtl/entry_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_entry_controller.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/entry_controller.sv
// entry_controller: keypad entry sequencer for the calculator input unit.
//
// Collects two BCD operands digit by digit under a movable cursor, latches
// the operator, launches the ALU with a start/done handshake and holds the
// result for display or chaining.
//
// Ports:
//   clk         system clock
//   reset       asynchronous reset, active-low
//   pre         raw key-press strobe (asynchronous to clk)
//   value       key code, stable while pre is high
//   clear       synchronous clear, active-high, highest priority
//   alu_done    one-cycle ALU completion pulse
//   alu_err     ALU error flag, valid with alu_done
//   alu_result  BCD result, valid with alu_done
//   operand_a   latched first operand
//   operand_b   latched second operand
//   op          operator: 00 add, 01 sub, 10 mul
//   start       one-cycle ALU launch pulse
//   busy        high while waiting on the ALU
//   cursor      current digit position, 0 = most significant
//   disp        entry/result buffer, digit i at [4*(DIGITS-1-i)+:4]
//   err         result error indicator
//
// state   | meaning
// --------+-----------------------------------------------
// ENTER_A | editing the first operand
// ENTER_B | editing the second operand, operator latched
// CALC    | ALU launched, waiting for alu_done; keys dropped
// RESULT  | result displayed; digit restarts, operator chains

module entry_controller #(
    parameter int DIGITS = 6,
    parameter int CW     = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pre,
    input  logic [3:0]          value,
    input  logic                clear,
    input  logic                alu_done,
    input  logic                alu_err,
    input  logic [4*DIGITS-1:0] alu_result,
    output logic [4*DIGITS-1:0] operand_a,
    output logic [4*DIGITS-1:0] operand_b,
    output logic [1:0]          op,
    output logic                start,
    output logic                busy,
    output logic [CW-1:0]       cursor,
    output logic [4*DIGITS-1:0] disp,
    output logic                err
);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        CALC    = 2'd2,
        RESULT  = 2'd3
    } state_t;

    localparam logic [CW-1:0] CUR_MAX = CW'(DIGITS - 1);

    state_t state_q, state_d;

    // Two-flop synchronizer; a press is the first cycle s0 is seen high.
    logic s0, s1, press;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else begin
            s0 <= pre;
            s1 <= s0;
        end
    end

    assign press = s0 & ~s1;

    logic k_digit, k_oper, k_left, k_right, k_equal;

    always_comb begin
        k_digit = press && (value <= 4'd9);
        k_oper  = press && (value >= 4'd10) && (value <= 4'd12);
        k_left  = press && (value == 4'd13);
        k_equal = press && (value == 4'd14);
        k_right = press && (value == 4'd15);
    end

    // Buffer with the key written at the cursor, and saturating cursor moves.
    logic [4*DIGITS-1:0] digit_wr;
    logic [CW-1:0]       cur_inc, cur_dec;
    logic [1:0]          key_op;

    always_comb begin
        digit_wr = disp;
        for (int i = 0; i < DIGITS; i++) begin
            if (cursor == CW'(i)) begin
                digit_wr[4*(DIGITS-1-i) +: 4] = value;
            end
        end
        cur_inc = (cursor == CUR_MAX)  ? cursor : cursor + CW'(1);
        cur_dec = (cursor == '0)       ? cursor : cursor - CW'(1);
        key_op  = 2'(value - 4'd10);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ENTER_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ENTER_A;
        end else begin
            case (state_q)
                ENTER_A: if (k_oper)   state_d = ENTER_B;
                ENTER_B: if (k_equal)  state_d = CALC;
                CALC:    if (alu_done) state_d = RESULT;
                RESULT: begin
                    if (k_digit)     state_d = ENTER_A;
                    else if (k_oper) state_d = ENTER_B;
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    logic [4*DIGITS-1:0] disp_d, operand_a_d, operand_b_d;
    logic [CW-1:0]       cursor_d;
    logic [1:0]          op_d;
    logic                err_d, start_d;

    always_comb begin
        disp_d      = disp;
        cursor_d    = cursor;
        operand_a_d = operand_a;
        operand_b_d = operand_b;
        op_d        = op;
        err_d       = err;
        start_d     = 1'b0;
        if (clear) begin
            disp_d      = '0;
            cursor_d    = '0;
            operand_a_d = '0;
            operand_b_d = '0;
            op_d        = 2'b00;
            err_d       = 1'b0;
        end else begin
            case (state_q)
                ENTER_A, ENTER_B: begin
                    if (k_digit) begin
                        disp_d   = digit_wr;
                        cursor_d = cur_inc;
                    end else if (k_left) begin
                        cursor_d = cur_dec;
                    end else if (k_right) begin
                        cursor_d = cur_inc;
                    end else if (k_oper) begin
                        op_d = key_op;
                        // In ENTER_B an operator only replaces the pending op.
                        if (state_q == ENTER_A) begin
                            operand_a_d = disp;
                            disp_d      = '0;
                            cursor_d    = '0;
                        end
                    end else if (k_equal && (state_q == ENTER_B)) begin
                        operand_b_d = disp;
                        start_d     = 1'b1;
                    end
                end
                CALC: begin
                    if (alu_done) begin
                        disp_d   = alu_result;
                        err_d    = alu_err;
                        cursor_d = '0;
                    end
                end
                RESULT: begin
                    if (k_digit) begin
                        disp_d                     = '0;
                        disp_d[4*DIGITS-1 -: 4]    = value;
                        cursor_d                   = CW'(1);
                        err_d                      = 1'b0;
                    end else if (k_oper) begin
                        // Chain the displayed result in as the first operand.
                        operand_a_d = disp;
                        op_d        = key_op;
                        disp_d      = '0;
                        cursor_d    = '0;
                        err_d       = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp      <= '0;
            cursor    <= '0;
            operand_a <= '0;
            operand_b <= '0;
            op        <= 2'b00;
            err       <= 1'b0;
            start     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            disp      <= disp_d;
            cursor    <= cursor_d;
            operand_a <= operand_a_d;
            operand_b <= operand_b_d;
            op        <= op_d;
            err       <= err_d;
            start     <= start_d;
            busy      <= (state_d == CALC);
        end
    end

endmodule

// File: tb/tb_entry_controller.sv
// tb_entry_controller: self-checking bench for entry_controller.
// Directed walk through the main entry/calc/result flow followed by random
// key, ALU-completion and clear traffic, all compared against a digit-array
// model of the calculator entry rules.
//
// Ports: none (top-level bench).

module tb_entry_controller;

    localparam int DIGITS = 6;
    localparam int CW     = 3;
    localparam int W      = 4 * DIGITS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          pre = 1'b0;
    logic [3:0]    value = 4'd0;
    logic          clear = 1'b0;
    logic          alu_done = 1'b0;
    logic          alu_err = 1'b0;
    logic [W-1:0]  alu_result = '0;
    logic [W-1:0]  operand_a, operand_b, disp;
    logic [1:0]    op;
    logic          start, busy, err;
    logic [CW-1:0] cursor;

    entry_controller #(.DIGITS(DIGITS), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pre        (pre),
        .value      (value),
        .clear      (clear),
        .alu_done   (alu_done),
        .alu_err    (alu_err),
        .alu_result (alu_result),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .op         (op),
        .start      (start),
        .busy       (busy),
        .cursor     (cursor),
        .disp       (disp),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int start_cnt = 0;

    always @(negedge clk) if (start) start_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: digits as an array, state as a small integer
    // (0 entering A, 1 entering B, 2 waiting on ALU, 3 showing result).
    int         m_dig[DIGITS];
    int         m_cur;
    int         m_state;
    logic [W-1:0] m_opa, m_opb;
    int         m_op;
    int         m_err;

    function automatic logic [W-1:0] pack();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) r[4*(DIGITS-1-i) +: 4] = m_dig[i][3:0];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
        m_cur = 0; m_state = 0; m_opa = '0; m_opb = '0; m_op = 0; m_err = 0;
    endtask

    task automatic model_key(input int k, output int exp_start);
        exp_start = 0;
        if (m_state == 0 || m_state == 1) begin
            if (k <= 9) begin
                m_dig[m_cur] = k;
                if (m_cur < DIGITS - 1) m_cur++;
            end else if (k == 13) begin
                if (m_cur > 0) m_cur--;
            end else if (k == 15) begin
                if (m_cur < DIGITS - 1) m_cur++;
            end else if (k >= 10 && k <= 12) begin
                m_op = k - 10;
                if (m_state == 0) begin
                    m_opa = pack();
                    for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
                    m_cur = 0;
                    m_state = 1;
                end
            end else if (k == 14 && m_state == 1) begin
                m_opb = pack();
                m_state = 2;
                exp_start = 1;
            end
        end else if (m_state == 3) begin
            if (k <= 9) begin
                for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
                m_dig[0] = k; m_cur = 1; m_err = 0; m_state = 0;
            end else if (k >= 10 && k <= 12) begin
                m_opa = pack();
                m_op = k - 10;
                for (int i = 0; i < DIGITS; i++) m_dig[i] = 0;
                m_cur = 0; m_err = 0; m_state = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".disp"},   32'(disp),      32'(pack()));
        chk({tag, ".cursor"}, 32'(cursor),    32'(m_cur));
        chk({tag, ".opa"},    32'(operand_a), 32'(m_opa));
        chk({tag, ".opb"},    32'(operand_b), 32'(m_opb));
        chk({tag, ".op"},     32'(op),        32'(m_op));
        chk({tag, ".err"},    32'(err),       32'(m_err));
        chk({tag, ".busy"},   32'(busy),      32'(m_state == 2));
    endtask

    task automatic press(input int k, input int hold, input string tag);
        int s0c, es;
        s0c = start_cnt;
        @(negedge clk);
        pre = 1'b1; value = 4'(k);
        repeat (hold) @(negedge clk);
        pre = 1'b0;
        repeat (3) @(negedge clk);
        model_key(k, es);
        chk({tag, ".start"}, 32'(start_cnt - s0c), 32'(es));
        check_all(tag);
    endtask

    task automatic alu_finish(input logic [W-1:0] res, input logic e, input string tag);
        @(negedge clk);
        alu_done = 1'b1; alu_result = res; alu_err = e;
        @(negedge clk);
        alu_done = 1'b0; alu_result = '0; alu_err = 1'b0;
        @(negedge clk);
        if (m_state == 2) begin
            for (int i = 0; i < DIGITS; i++) m_dig[i] = int'(res[4*(DIGITS-1-i) +: 4]);
            m_err = int'(e); m_cur = 0; m_state = 3;
        end
        check_all(tag);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        model_reset();
        check_all(tag);
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    initial begin
        int sc;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        chk("reset.start", 32'(start), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        press(1, 4, "d1"); press(2, 4, "d2"); press(3, 4, "d3");
        chk("d123.disp", 32'(disp), 32'h123000);
        chk("d123.cursor", 32'(cursor), 32'd3);

        for (int i = 0; i < 4; i++) press(15, 4, "right");
        chk("right_sat", 32'(cursor), 32'd5);
        for (int i = 0; i < 7; i++) press(13, 4, "left");
        chk("left_sat", 32'(cursor), 32'd0);
        press(9, 4, "d9");
        chk("d9.disp", 32'(disp), 32'h923000);
        chk("d9.cursor", 32'(cursor), 32'd1);

        do_clear("clr1");
        press(1, 4, "e1"); press(2, 4, "e2"); press(10, 4, "add");
        press(5, 4, "e5");
        sc = start_cnt;
        press(14, 4, "eq");
        chk("eq.opa", 32'(operand_a), 32'h120000);
        chk("eq.opb", 32'(operand_b), 32'h500000);
        chk("eq.op", 32'(op), 32'd0);
        chk("eq.start_once", 32'(start_cnt - sc), 32'd1);
        chk("eq.busy", 32'(busy), 32'd1);

        press(7, 4, "calc_key");
        alu_finish(24'h170000, 1'b0, "done1");
        chk("done1.disp", 32'(disp), 32'h170000);
        chk("done1.busy", 32'(busy), 32'd0);

        press(11, 4, "chain_sub");
        chk("chain.opa", 32'(operand_a), 32'h170000);
        chk("chain.op", 32'(op), 32'd1);
        press(14, 4, "eq2");
        alu_finish(24'h250000, 1'b1, "done2");
        chk("done2.err", 32'(err), 32'd1);
        press(4, 4, "restart4");
        chk("restart.disp", 32'(disp), 32'h400000);
        chk("restart.cursor", 32'(cursor), 32'd1);

        press(3, 20, "hold");
        chk("hold.disp", 32'(disp), 32'h430000);
        chk("hold.cursor", 32'(cursor), 32'd2);

        // Clear landing on the same edge as the press event.
        @(negedge clk);
        pre = 1'b1; value = 4'd8;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
        pre = 1'b0;
        repeat (3) @(negedge clk);
        model_reset();
        check_all("clr_press");

        // Asynchronous reset while waiting on the ALU.
        press(1, 4, "r1"); press(12, 4, "mul"); press(2, 4, "r2"); press(14, 4, "req");
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.start", 32'(start), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int it = 0; it < 300; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (m_state == 2 && r < 50) begin
                alu_finish(rand_bcd(), 1'($urandom_range(0, 1)), "rnd_done");
            end else if (r < 3) begin
                do_clear("rnd_clr");
            end else if (r < 6) begin
                alu_finish(rand_bcd(), 1'($urandom_range(0, 1)), "rnd_stray");
            end else if (r < 50) begin
                press(int'($urandom_range(0, 9)), int'($urandom_range(1, 6)), "rnd_dig");
            end else begin
                press(int'($urandom_range(10, 15)), int'($urandom_range(1, 6)), "rnd_fn");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
